// File: rtl/exe_stage_if.sv
// EXE stage bundle: ID/EXE inputs, MEM handshake, forwarding, data SRAM and EXE/MEM outputs.
interface exe_stage_if #(
  parameter int unsigned CNT_W = 32
);
  logic             es_valid;
  logic [31:0]      es_pc;
  logic [31:0]      es_alu_src1;
  logic [31:0]      es_alu_src2;
  logic [11:0]      es_alu_op;
  logic             es_sram_en;
  logic [3:0]       es_sram_we;
  logic [31:0]      es_st_data;
  logic [3:0]       es_rf_we;
  logic [4:0]       es_rf_waddr;
  logic [4:0]       ds_rf_raddr1;
  logic [4:0]       ds_rf_raddr2;
  logic             ms_allow_in;
  logic             es_allow_in;
  logic             es_ready_go;
  logic             load_use_stall;
  logic [3:0]       es_fwd_we;
  logic [4:0]       es_fwd_waddr;
  logic [31:0]      es_fwd_wdata;
  logic             data_sram_en;
  logic [3:0]       data_sram_we;
  logic [31:0]      data_sram_addr;
  logic [31:0]      data_sram_wdata;
  logic             ms_valid;
  logic [31:0]      ms_pc;
  logic [31:0]      ms_alu_result;
  logic             ms_res_from_mem;
  logic [3:0]       ms_rf_we;
  logic [4:0]       ms_rf_waddr;
  logic [CNT_W-1:0] stall_cnt;

  // Drives the stage (ID/EXE register, MEM stage, testbench)
  modport master (
    output es_valid, es_pc, es_alu_src1, es_alu_src2, es_alu_op, es_sram_en, es_sram_we,
           es_st_data, es_rf_we, es_rf_waddr, ds_rf_raddr1, ds_rf_raddr2, ms_allow_in,
    input  es_allow_in, es_ready_go, load_use_stall, es_fwd_we, es_fwd_waddr, es_fwd_wdata,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata, ms_valid, ms_pc,
           ms_alu_result, ms_res_from_mem, ms_rf_we, ms_rf_waddr, stall_cnt
  );

  // The EXE stage itself
  modport slave (
    input  es_valid, es_pc, es_alu_src1, es_alu_src2, es_alu_op, es_sram_en, es_sram_we,
           es_st_data, es_rf_we, es_rf_waddr, ds_rf_raddr1, ds_rf_raddr2, ms_allow_in,
    output es_allow_in, es_ready_go, load_use_stall, es_fwd_we, es_fwd_waddr, es_fwd_wdata,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata, ms_valid, ms_pc,
           ms_alu_result, ms_res_from_mem, ms_rf_we, ms_rf_waddr, stall_cnt
  );
endinterface

// File: rtl/exe_stage.sv
// LA32R execute stage: one-hot ALU, data SRAM issue, EXE->ID forwarding,
// load-use hazard detection and the EXE/MEM pipeline register.
module exe_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic      clk,
  input  logic      reset,
  exe_stage_if.slave bus
);
  logic [31:0]      w_alu_result;
  logic [31:0]      w_add;
  logic [31:0]      w_sub;
  logic [31:0]      w_sra;
  logic [4:0]       w_sa;
  logic             w_slt;
  logic             w_sltu;
  logic             w_go;
  logic             w_stall;

  logic             r_ms_valid;
  logic [31:0]      r_ms_pc;
  logic [31:0]      r_ms_alu_result;
  logic             r_ms_res_from_mem;
  logic [3:0]       r_ms_rf_we;
  logic [4:0]       r_ms_rf_waddr;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_sa   = bus.es_alu_src2[4:0];
  assign w_add  = bus.es_alu_src1 + bus.es_alu_src2;
  assign w_sub  = bus.es_alu_src1 - bus.es_alu_src2;
  assign w_slt  = $signed(bus.es_alu_src1) < $signed(bus.es_alu_src2);
  assign w_sltu = bus.es_alu_src1 < bus.es_alu_src2;
  assign w_sra  = 32'($signed(bus.es_alu_src1) >>> w_sa);

  // ALU result: OR of every selected op, so zero-hot yields 0
  always_comb begin
    w_alu_result = '0;
    if (bus.es_alu_op[0])  w_alu_result |= w_add;
    if (bus.es_alu_op[1])  w_alu_result |= w_sub;
    if (bus.es_alu_op[2])  w_alu_result |= {31'b0, w_slt};
    if (bus.es_alu_op[3])  w_alu_result |= {31'b0, w_sltu};
    if (bus.es_alu_op[4])  w_alu_result |= bus.es_alu_src1 & bus.es_alu_src2;
    if (bus.es_alu_op[5])  w_alu_result |= ~(bus.es_alu_src1 | bus.es_alu_src2);
    if (bus.es_alu_op[6])  w_alu_result |= bus.es_alu_src1 | bus.es_alu_src2;
    if (bus.es_alu_op[7])  w_alu_result |= bus.es_alu_src1 ^ bus.es_alu_src2;
    if (bus.es_alu_op[8])  w_alu_result |= bus.es_alu_src1 << w_sa;
    if (bus.es_alu_op[9])  w_alu_result |= bus.es_alu_src1 >> w_sa;
    if (bus.es_alu_op[10]) w_alu_result |= w_sra;
    if (bus.es_alu_op[11]) w_alu_result |= bus.es_alu_src2;
  end

  // Memory access only fires in the cycle the instruction actually moves to MEM,
  // so a back-pressured store is issued exactly once.
  assign w_go = bus.es_valid & bus.ms_allow_in;

  assign w_stall = bus.es_valid & bus.es_sram_en & (|bus.es_rf_we) & (bus.es_rf_waddr != 5'd0) &
                   ((bus.es_rf_waddr == bus.ds_rf_raddr1) |
                    (bus.es_rf_waddr == bus.ds_rf_raddr2));

  assign bus.es_ready_go     = 1'b1;
  assign bus.es_allow_in     = ~bus.es_valid | (bus.es_ready_go & bus.ms_allow_in);
  assign bus.data_sram_en    = w_go & (bus.es_sram_en | (|bus.es_sram_we));
  assign bus.data_sram_we    = w_go ? bus.es_sram_we : 4'b0;
  assign bus.data_sram_addr  = w_alu_result;
  assign bus.data_sram_wdata = bus.es_st_data;
  assign bus.es_fwd_we       = bus.es_valid ? bus.es_rf_we : 4'b0;
  assign bus.es_fwd_waddr    = bus.es_rf_waddr;
  assign bus.es_fwd_wdata    = w_alu_result;
  assign bus.load_use_stall  = w_stall;

  // EXE/MEM register: advances only when MEM accepts, payload only for valid slots
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ms_valid        <= 1'b0;
      r_ms_pc           <= RESET_PC;
      r_ms_alu_result   <= '0;
      r_ms_res_from_mem <= 1'b0;
      r_ms_rf_we        <= '0;
      r_ms_rf_waddr     <= '0;
    end else if (bus.ms_allow_in) begin
      r_ms_valid <= bus.es_valid & bus.es_ready_go;
      if (bus.es_valid) begin
        r_ms_pc           <= bus.es_pc;
        r_ms_alu_result   <= w_alu_result;
        r_ms_res_from_mem <= bus.es_sram_en;
        r_ms_rf_we        <= bus.es_rf_we;
        r_ms_rf_waddr     <= bus.es_rf_waddr;
      end
    end
  end

  // Load-use stall cycle counter, wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.ms_valid        = r_ms_valid;
  assign bus.ms_pc           = r_ms_pc;
  assign bus.ms_alu_result   = r_ms_alu_result;
  assign bus.ms_res_from_mem = r_ms_res_from_mem;
  assign bus.ms_rf_we        = r_ms_rf_we;
  assign bus.ms_rf_waddr     = r_ms_rf_waddr;
  assign bus.stall_cnt       = r_stall_cnt;
endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed cases plus randomized traffic
// against a behavioural model of the stage.
module tb_exe_stage;
  localparam logic [31:0] RESET_PC = 32'h1c000000;
  localparam int unsigned CNT_W    = 32;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;

  exe_stage_if #(.CNT_W(CNT_W)) bus ();

  exe_stage #(
    .RESET_PC(RESET_PC),
    .CNT_W   (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Model of the EXE/MEM register contents
  logic             m_valid;
  logic [31:0]      m_pc;
  logic [31:0]      m_res;
  logic             m_rfm;
  logic [3:0]       m_we;
  logic [4:0]       m_waddr;
  logic [CNT_W-1:0] m_cnt;

  function automatic logic [31:0] alu_ref(input logic [11:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    logic [31:0] ones;
    int sh;
    r    = 32'h0;
    ones = 32'hffffffff;
    sh   = int'(b % 32);
    for (int i = 0; i < 12; i++) begin
      if (op[i]) begin
        case (i)
          0:  r = r | (a + b);
          1:  r = r | (a - b);
          2:  r = r | ((int'(a) < int'(b)) ? 32'd1 : 32'd0);
          3:  r = r | ((longint'(a) < longint'(b)) ? 32'd1 : 32'd0);
          4:  r = r | (a & b);
          5:  r = r | ~(a | b);
          6:  r = r | (a | b);
          7:  r = r | (a ^ b);
          8:  r = r | (a << sh);
          9:  r = r | (a >> sh);
          10: r = r | ((a >> sh) | (a[31] ? ~(ones >> sh) : 32'h0));
          default: r = r | b;
        endcase
      end
    end
    return r;
  endfunction

  function automatic logic stall_ref(input logic v, input logic ld, input logic [3:0] we,
                                     input logic [4:0] wa, input logic [4:0] r1,
                                     input logic [4:0] r2);
    return v && ld && we != 4'd0 && wa != 5'd0 && (wa == r1 || wa == r2);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_pc = RESET_PC; m_res = 32'h0; m_rfm = 1'b0;
    m_we = 4'h0; m_waddr = 5'h0; m_cnt = '0;
  endtask

  task automatic drive_idle();
    bus.es_valid = 1'b0; bus.es_pc = 32'h0; bus.es_alu_src1 = 32'h0; bus.es_alu_src2 = 32'h0;
    bus.es_alu_op = 12'h0; bus.es_sram_en = 1'b0; bus.es_sram_we = 4'h0; bus.es_st_data = 32'h0;
    bus.es_rf_we = 4'h0; bus.es_rf_waddr = 5'h0; bus.ds_rf_raddr1 = 5'h0;
    bus.ds_rf_raddr2 = 5'h0; bus.ms_allow_in = 1'b1;
  endtask

  // One clock: inputs are held across the edge, model follows the stage rules
  task automatic tick();
    logic st;
    @(posedge clk);
    st = stall_ref(bus.es_valid, bus.es_sram_en, bus.es_rf_we, bus.es_rf_waddr,
                   bus.ds_rf_raddr1, bus.ds_rf_raddr2);
    if (bus.ms_allow_in) begin
      m_valid = bus.es_valid;
      if (bus.es_valid) begin
        m_pc    = bus.es_pc;
        m_res   = alu_ref(bus.es_alu_op, bus.es_alu_src1, bus.es_alu_src2);
        m_rfm   = bus.es_sram_en;
        m_we    = bus.es_rf_we;
        m_waddr = bus.es_rf_waddr;
      end
    end
    if (st) m_cnt = m_cnt + 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    model_reset();
    #3;
    vectors++;
    if (bus.ms_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_ms_valid got %0h want 0", bus.ms_valid);
    end
    vectors++;
    if (bus.ms_pc !== RESET_PC) begin
      miscompares++; $display("FAIL reset_ms_pc got %h want %h", bus.ms_pc, RESET_PC);
    end
    vectors++;
    if (bus.ms_alu_result !== 32'h0 || bus.ms_rf_we !== 4'h0 || bus.ms_rf_waddr !== 5'h0 ||
        bus.ms_res_from_mem !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ms_fields got res=%h we=%h wa=%h rfm=%b want all 0",
               bus.ms_alu_result, bus.ms_rf_we, bus.ms_rf_waddr, bus.ms_res_from_mem);
    end
    vectors++;
    if (bus.stall_cnt !== '0) begin
      miscompares++; $display("FAIL reset_stall_cnt got %0d want 0", bus.stall_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    bus.es_valid = 1'b1; bus.es_pc = 32'h1c000010; bus.es_alu_op = 12'h001;
    bus.es_alu_src1 = 32'h7fffffff; bus.es_alu_src2 = 32'h1;
    bus.es_rf_we = 4'hf; bus.es_rf_waddr = 5'd3; bus.ms_allow_in = 1'b1;
    #1;
    vectors++;
    if (bus.es_fwd_wdata !== 32'h80000000) begin
      miscompares++; $display("FAIL add_fwd_wdata got %h want 80000000", bus.es_fwd_wdata);
    end
    vectors++;
    if (bus.es_fwd_we !== 4'hf || bus.es_fwd_waddr !== 5'd3) begin
      miscompares++;
      $display("FAIL add_fwd_ctl got we=%h wa=%0d want f/3", bus.es_fwd_we, bus.es_fwd_waddr);
    end
    tick();
    vectors++;
    if (bus.ms_alu_result !== 32'h80000000 || bus.ms_valid !== 1'b1 ||
        bus.ms_pc !== 32'h1c000010) begin
      miscompares++;
      $display("FAIL add_ms got res=%h v=%b pc=%h want 80000000/1/1c000010",
               bus.ms_alu_result, bus.ms_valid, bus.ms_pc);
    end
  endtask

  task automatic test_alu_directed();
    logic [11:0] ops[7];
    logic [31:0] as[7];
    logic [31:0] bs[7];
    logic [31:0] exps[7];
    ops = '{12'h400, 12'h004, 12'h008, 12'h020, 12'h800, 12'h000, 12'h050};
    as  = '{32'h80000000, 32'hffffffff, 32'hffffffff, 32'h0f0f0000, 32'h1234, 32'hffff, 32'hf0};
    bs  = '{32'h24, 32'h1, 32'h1, 32'h00000f0f, 32'habcde000, 32'h1, 32'h0f};
    exps = '{32'hf8000000, 32'h1, 32'h0, 32'hf0f0f0f0, 32'habcde000, 32'h0, 32'hff};
    bus.es_valid = 1'b1; bus.ms_allow_in = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.es_alu_op = ops[i]; bus.es_alu_src1 = as[i]; bus.es_alu_src2 = bs[i];
      #1;
      vectors++;
      if (bus.es_fwd_wdata !== exps[i] || bus.data_sram_addr !== exps[i]) begin
        miscompares++;
        $display("FAIL alu_dir[%0d] op=%h got %h/%h want %h", i, ops[i], bus.es_fwd_wdata,
                 bus.data_sram_addr, exps[i]);
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    logic [CNT_W-1:0] c0;
    bus.es_valid = 1'b1; bus.es_sram_en = 1'b1; bus.es_sram_we = 4'h0; bus.es_rf_we = 4'hf;
    bus.es_rf_waddr = 5'd5; bus.ds_rf_raddr1 = 5'd7; bus.ds_rf_raddr2 = 5'd5;
    bus.es_alu_op = 12'h001; bus.es_alu_src1 = 32'h100; bus.es_alu_src2 = 32'h4;
    c0 = m_cnt;
    #1;
    vectors++;
    if (bus.load_use_stall !== 1'b1 || bus.data_sram_en !== 1'b1) begin
      miscompares++;
      $display("FAIL load_use_hit got stall=%b en=%b want 1/1", bus.load_use_stall,
               bus.data_sram_en);
    end
    tick();
    vectors++;
    if (bus.stall_cnt !== c0 + 1'b1 || bus.ms_res_from_mem !== 1'b1) begin
      miscompares++;
      $display("FAIL load_use_cnt got cnt=%0d rfm=%b want %0d/1", bus.stall_cnt,
               bus.ms_res_from_mem, c0 + 1'b1);
    end
    bus.es_rf_waddr = 5'd0; bus.ds_rf_raddr1 = 5'd0; bus.ds_rf_raddr2 = 5'd0;
    #1;
    vectors++;
    if (bus.load_use_stall !== 1'b0) begin
      miscompares++; $display("FAIL load_use_r0 got %b want 0", bus.load_use_stall);
    end
    tick();
    vectors++;
    if (bus.stall_cnt !== c0 + 1'b1) begin
      miscompares++; $display("FAIL load_use_r0_cnt got %0d want %0d", bus.stall_cnt, c0 + 1'b1);
    end
    bus.es_sram_en = 1'b0;
  endtask

  task automatic test_store_backpressure();
    logic [31:0] held_res;
    logic        held_v;
    held_res = m_res; held_v = m_valid;
    bus.es_valid = 1'b1; bus.es_sram_en = 1'b0; bus.es_sram_we = 4'hf; bus.es_rf_we = 4'h0;
    bus.es_alu_op = 12'h001; bus.es_alu_src1 = 32'h2000; bus.es_alu_src2 = 32'h8;
    bus.es_st_data = 32'hdeadbeef; bus.es_pc = 32'h1c000040; bus.ms_allow_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (bus.data_sram_we !== 4'h0 || bus.data_sram_en !== 1'b0 || bus.es_allow_in !== 1'b0) begin
        miscompares++;
        $display("FAIL store_bp[%0d] got we=%h en=%b ain=%b want 0/0/0", i, bus.data_sram_we,
                 bus.data_sram_en, bus.es_allow_in);
      end
      tick();
      vectors++;
      if (bus.ms_alu_result !== held_res || bus.ms_valid !== held_v) begin
        miscompares++;
        $display("FAIL store_hold[%0d] got res=%h v=%b want %h/%b", i, bus.ms_alu_result,
                 bus.ms_valid, held_res, held_v);
      end
    end
    bus.ms_allow_in = 1'b1;
    #1;
    vectors++;
    if (bus.data_sram_we !== 4'hf || bus.data_sram_en !== 1'b1 ||
        bus.data_sram_addr !== 32'h2008 || bus.data_sram_wdata !== 32'hdeadbeef) begin
      miscompares++;
      $display("FAIL store_issue got we=%h en=%b a=%h d=%h want f/1/2008/deadbeef",
               bus.data_sram_we, bus.data_sram_en, bus.data_sram_addr, bus.data_sram_wdata);
    end
    tick();
    bus.es_valid = 1'b0;
    #1;
    vectors++;
    if (bus.data_sram_we !== 4'h0 || bus.ms_valid !== 1'b1 || bus.ms_pc !== 32'h1c000040) begin
      miscompares++;
      $display("FAIL store_once got we=%h v=%b pc=%h want 0/1/1c000040", bus.data_sram_we,
               bus.ms_valid, bus.ms_pc);
    end
    bus.es_sram_we = 4'h0;
  endtask

  task automatic test_bubble();
    bus.es_valid = 1'b0; bus.ms_allow_in = 1'b1; bus.es_sram_en = 1'b1; bus.es_sram_we = 4'hf;
    bus.es_rf_we = 4'hf; bus.es_rf_waddr = 5'd9; bus.ds_rf_raddr1 = 5'd9;
    #1;
    vectors++;
    if (bus.data_sram_en !== 1'b0 || bus.data_sram_we !== 4'h0 || bus.es_fwd_we !== 4'h0 ||
        bus.load_use_stall !== 1'b0 || bus.es_allow_in !== 1'b1) begin
      miscompares++;
      $display("FAIL bubble_comb got en=%b we=%h fwe=%h st=%b ain=%b want 0/0/0/0/1",
               bus.data_sram_en, bus.data_sram_we, bus.es_fwd_we, bus.load_use_stall,
               bus.es_allow_in);
    end
    tick();
    vectors++;
    if (bus.ms_valid !== 1'b0) begin
      miscompares++; $display("FAIL bubble_ms_valid got %b want 0", bus.ms_valid);
    end
  endtask

  task automatic test_random();
    logic [31:0] e_res;
    logic        e_st;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0:       bus.es_alu_op = 12'h0;
        1:       bus.es_alu_op = 12'($urandom);
        default: bus.es_alu_op = 12'h1 << $urandom_range(0, 11);
      endcase
      bus.es_alu_src1  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      bus.es_alu_src2  = ($urandom_range(0, 7) == 0) ? 32'hffffffff : $urandom;
      bus.es_valid     = ($urandom_range(0, 3) != 0);
      bus.ms_allow_in  = ($urandom_range(0, 3) != 0);
      bus.es_pc        = $urandom;
      bus.es_sram_en   = $urandom_range(0, 1) == 1;
      bus.es_sram_we   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      bus.es_st_data   = $urandom;
      bus.es_rf_we     = 4'($urandom);
      bus.es_rf_waddr  = 5'($urandom);
      bus.ds_rf_raddr1 = ($urandom_range(0, 2) == 0) ? bus.es_rf_waddr : 5'($urandom);
      bus.ds_rf_raddr2 = ($urandom_range(0, 2) == 0) ? bus.es_rf_waddr : 5'($urandom);
      e_res = alu_ref(bus.es_alu_op, bus.es_alu_src1, bus.es_alu_src2);
      e_st  = stall_ref(bus.es_valid, bus.es_sram_en, bus.es_rf_we, bus.es_rf_waddr,
                        bus.ds_rf_raddr1, bus.ds_rf_raddr2);
      #1;
      vectors++;
      if (bus.es_fwd_wdata !== e_res || bus.data_sram_addr !== e_res) begin
        miscompares++;
        $display("FAIL rnd_alu[%0d] op=%h a=%h b=%h got %h want %h", n, bus.es_alu_op,
                 bus.es_alu_src1, bus.es_alu_src2, bus.es_fwd_wdata, e_res);
      end
      vectors++;
      if (bus.load_use_stall !== e_st) begin
        miscompares++; $display("FAIL rnd_stall[%0d] got %b want %b", n, bus.load_use_stall, e_st);
      end
      vectors++;
      if (bus.data_sram_en !== (bus.es_valid && bus.ms_allow_in &&
                                (bus.es_sram_en || bus.es_sram_we != 4'h0)) ||
          bus.data_sram_we !== ((bus.es_valid && bus.ms_allow_in) ? bus.es_sram_we : 4'h0) ||
          bus.data_sram_wdata !== bus.es_st_data) begin
        miscompares++;
        $display("FAIL rnd_sram[%0d] got en=%b we=%h d=%h", n, bus.data_sram_en,
                 bus.data_sram_we, bus.data_sram_wdata);
      end
      vectors++;
      if (bus.es_fwd_we !== (bus.es_valid ? bus.es_rf_we : 4'h0) ||
          bus.es_allow_in !== (!bus.es_valid || bus.ms_allow_in) || bus.es_ready_go !== 1'b1) begin
        miscompares++;
        $display("FAIL rnd_ctl[%0d] got fwe=%h ain=%b rg=%b", n, bus.es_fwd_we, bus.es_allow_in,
                 bus.es_ready_go);
      end
      tick();
      vectors++;
      if (bus.ms_valid !== m_valid || bus.ms_pc !== m_pc || bus.ms_alu_result !== m_res ||
          bus.ms_res_from_mem !== m_rfm || bus.ms_rf_we !== m_we || bus.ms_rf_waddr !== m_waddr ||
          bus.stall_cnt !== m_cnt) begin
        miscompares++;
        $display("FAIL rnd_ms[%0d] got v=%b pc=%h r=%h m=%b we=%h wa=%0d c=%0d want %b %h %h %b %h %0d %0d",
                 n, bus.ms_valid, bus.ms_pc, bus.ms_alu_result, bus.ms_res_from_mem,
                 bus.ms_rf_we, bus.ms_rf_waddr, bus.stall_cnt, m_valid, m_pc, m_res, m_rfm,
                 m_we, m_waddr, m_cnt);
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive_idle();
    bus.es_valid = 1'b1; bus.es_pc = 32'h1c0000a0; bus.es_alu_op = 12'h040;
    bus.es_alu_src1 = 32'h11; bus.es_alu_src2 = 32'h22; bus.es_rf_we = 4'hf;
    bus.es_rf_waddr = 5'd4;
    tick();
    vectors++;
    if (bus.ms_valid !== 1'b1) begin
      miscompares++; $display("FAIL midrst_pre got ms_valid=%b want 1", bus.ms_valid);
    end
    #1;
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.ms_valid !== 1'b0 || bus.ms_pc !== RESET_PC || bus.stall_cnt !== '0) begin
      miscompares++;
      $display("FAIL midrst_async got v=%b pc=%h c=%0d want 0/%h/0", bus.ms_valid, bus.ms_pc,
               bus.stall_cnt, RESET_PC);
    end
    vectors++;
    if (bus.es_fwd_wdata !== 32'h33 || bus.es_fwd_we !== 4'hf) begin
      miscompares++;
      $display("FAIL midrst_comb got %h/%h want 33/f", bus.es_fwd_wdata, bus.es_fwd_we);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_directed();
    test_load_use();
    test_store_backpressure();
    test_bubble();
    test_random();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
